// File: rtl/mst_fifo_ctl_mc.sv
// Multi-channel FIFO controller: partitions one simple-dual-port SRAM into
// CH_NUM circular FIFOs (multi-channel mode) or one full-depth FIFO (245 mode).
// Read latency is two cycles: request edge -> mem_re cycle -> mem_q/fifo_dvld cycle.
module mst_fifo_ctl_mc #(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned CHW       = 2,
  parameter int unsigned DW        = 36,
  parameter int unsigned AW        = 14,
  parameter int unsigned AFULL_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mltcn,
  input  logic              fifowr,
  input  logic [CHW-1:0]    fifowrid,
  input  logic [DW-1:0]     fifo_din,
  input  logic              fiford,
  input  logic [CHW-1:0]    fifordid,
  output logic [DW-1:0]     fifo_dout,
  output logic              fifo_dvld,
  output logic [CH_NUM-1:0] fifoafull,
  output logic [CH_NUM-1:0] fifonempt,
  input  logic [CH_NUM-1:0] flush,
  output logic [CH_NUM-1:0] ovf,
  output logic [CH_NUM-1:0] udf,
  input  logic [CHW-1:0]    lvlsel,
  output logic [AW:0]       lvl,
  output logic              mem_we,
  output logic [AW-1:0]     mem_wa,
  output logic [DW-1:0]     mem_d,
  output logic              mem_re,
  output logic [AW-1:0]     mem_ra,
  input  logic [DW-1:0]     mem_q
);

  localparam int unsigned PW          = AW - CHW;
  localparam logic [AW:0] DEPTH_MC    = (AW+1)'(1) << PW;
  localparam logic [AW:0] DEPTH_SC    = (AW+1)'(1) << AW;
  localparam logic [AW-1:0] PTR_MASK_MC = AW'(DEPTH_MC - (AW+1)'(1));

  logic                mltcn_q;
  logic [AW-1:0]       wptr_q [CH_NUM];
  logic [AW-1:0]       rptr_q [CH_NUM];
  logic [AW:0]         cnt_q  [CH_NUM];
  logic [CH_NUM-1:0]   ovf_q, udf_q;
  logic [AW:0]         lvl_q;
  logic                mem_we_q, mem_re_q, fifo_dvld_q;
  logic [AW-1:0]       mem_wa_q, mem_ra_q;
  logic [DW-1:0]       mem_d_q;

  logic [AW:0]         depth, afull_thr;
  logic [AW-1:0]       ptr_mask;
  logic [CH_NUM-1:0]   ch_act;
  logic                mode_chg;
  logic                wr_act, wr_acc, rd_act, rd_acc;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic [CH_NUM-1:0]   wr_sel, rd_sel, ovf_set, udf_set;
  logic [AW-1:0]       wptr_inc [CH_NUM];
  logic [AW-1:0]       rptr_inc [CH_NUM];

  // Request qualification, addressing and status flags from registered state.
  always_comb begin
    depth     = mltcn_q ? DEPTH_MC : DEPTH_SC;
    afull_thr = depth - (AW+1)'(AFULL_GAP);
    ptr_mask  = mltcn_q ? PTR_MASK_MC : '1;
    // A mode switch clears every channel, so requests in that cycle are dropped.
    mode_chg  = (mltcn != mltcn_q);
    for (int c = 0; c < CH_NUM; c++) begin
      ch_act[c] = mltcn_q || (c == 0);
    end

    wr_act = fifowr && ch_act[fifowrid] && !flush[fifowrid] && !mode_chg;
    wr_acc = wr_act && (cnt_q[fifowrid] != depth);
    rd_act = fiford && ch_act[fifordid] && !flush[fifordid] && !mode_chg;
    rd_acc = rd_act && (cnt_q[fifordid] != '0);

    wr_addr = mltcn_q ? {fifowrid, wptr_q[fifowrid][PW-1:0]} : wptr_q[fifowrid];
    rd_addr = mltcn_q ? {fifordid, rptr_q[fifordid][PW-1:0]} : rptr_q[fifordid];

    for (int c = 0; c < CH_NUM; c++) begin
      wr_sel[c]   = wr_acc && (fifowrid == CHW'(c));
      rd_sel[c]   = rd_acc && (fifordid == CHW'(c));
      ovf_set[c]  = wr_act && !wr_acc && (fifowrid == CHW'(c));
      udf_set[c]  = rd_act && !rd_acc && (fifordid == CHW'(c));
      wptr_inc[c] = (wptr_q[c] + AW'(1)) & ptr_mask;
      rptr_inc[c] = (rptr_q[c] + AW'(1)) & ptr_mask;
      fifonempt[c] = (cnt_q[c] != '0);
      fifoafull[c] = !ch_act[c] || (cnt_q[c] >= afull_thr);
    end
  end

  // Per-channel pointers, counts and sticky flags; flush and mode change clear a channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mltcn_q <= mltcn;
      ovf_q   <= '0;
      udf_q   <= '0;
      lvl_q   <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      mltcn_q <= mltcn;
      lvl_q   <= cnt_q[lvlsel];
      for (int c = 0; c < CH_NUM; c++) begin
        if (mode_chg || flush[c]) begin
          wptr_q[c] <= '0;
          rptr_q[c] <= '0;
          cnt_q[c]  <= '0;
          ovf_q[c]  <= 1'b0;
          udf_q[c]  <= 1'b0;
        end else begin
          if (wr_sel[c]) wptr_q[c] <= wptr_inc[c];
          if (rd_sel[c]) rptr_q[c] <= rptr_inc[c];
          case ({wr_sel[c], rd_sel[c]})
            2'b10:   cnt_q[c] <= cnt_q[c] + (AW+1)'(1);
            2'b01:   cnt_q[c] <= cnt_q[c] - (AW+1)'(1);
            default: cnt_q[c] <= cnt_q[c];
          endcase
          if (ovf_set[c]) ovf_q[c] <= 1'b1;
          if (udf_set[c]) udf_q[c] <= 1'b1;
        end
      end
    end
  end

  // Registered SRAM port and read-data valid pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      fifo_dvld_q <= 1'b0;
      mem_wa_q    <= '0;
      mem_ra_q    <= '0;
      mem_d_q     <= '0;
    end else begin
      mem_we_q    <= wr_acc;
      mem_re_q    <= rd_acc;
      // Reads already in the SRAM complete even if their channel is flushed.
      fifo_dvld_q <= mem_re_q;
      if (wr_acc) begin
        mem_wa_q <= wr_addr;
        mem_d_q  <= fifo_din;
      end
      if (rd_acc) mem_ra_q <= rd_addr;
    end
  end

  assign fifo_dout = mem_q;
  assign fifo_dvld = fifo_dvld_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign lvl       = lvl_q;
  assign mem_we    = mem_we_q;
  assign mem_wa    = mem_wa_q;
  assign mem_d     = mem_d_q;
  assign mem_re    = mem_re_q;
  assign mem_ra    = mem_ra_q;

endmodule
